// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin scheduler sharing one byte-wide UART transmitter among NREQ producers.
// Optional feature macro UART_ARB_LOCK_EN lets a requester keep ownership across a multi-byte message.
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int BUSY_TO = 16
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] dat_i,
    input  logic [NREQ-1:0]   lock_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o,
    input  logic              uart_busy_i,
    output logic              busy_o,
    output logic              err_o,
    input  logic              err_clr_i
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(BUSY_TO + 1);
    localparam logic [CW-1:0]   TO_CNT = CW'(BUSY_TO);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            wr_q, wr_d;
    logic [7:0]      udat_q, udat_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] eligible;
    logic            found;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick;

`ifdef UART_ARB_LOCK_EN
    logic            lock_vld_q, lock_vld_d;
    logic [IW-1:0]   lock_own_q, lock_own_d;
`else
    logic            unused_lock;
    assign unused_lock = ^lock_i;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        udat_d   = udat_q;
        err_d    = err_clr_i ? 1'b0 : err_q;
        eligible = req_i;
        found    = 1'b0;
        cand     = '0;
        pick     = '0;
`ifdef UART_ARB_LOCK_EN
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        // A held lock narrows eligibility to its owner; a dropped lock frees arbitration this same cycle.
        if (state_q == IDLE && lock_vld_q) begin
            if (lock_i[lock_own_q]) begin
                eligible = req_i & (ONE << lock_own_q);
            end else begin
                lock_vld_d = 1'b0;
            end
        end
`endif
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (found && !uart_busy_i) begin
                    win_d   = pick;
                    udat_d  = dat_i[{pick, 3'b000} +: 8];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A transmitter that never acknowledges drops the byte; the producer was already acked.
                if (uart_busy_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == TO_CNT) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
`ifdef UART_ARB_LOCK_EN
                if (lock_i[win_q]) begin
                    lock_vld_d = 1'b1;
                    lock_own_d = win_q;
                end
`endif
                if (!uart_busy_i) begin
                    last_d  = win_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_d    = (state_d == LOAD);
        ack_d   = wr_d ? (ONE << win_d) : '0;
        grant_d = (state_d != IDLE) ? (ONE << win_d) : '0;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
            wr_q    <= 1'b0;
            udat_q  <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            udat_q  <= udat_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_ARB_LOCK_EN
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`endif

    assign ack_o      = ack_q;
    assign grant_o    = grant_q;
    assign uart_wr_o  = wr_q;
    assign uart_dat_o = udat_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: transaction-level model plus directed scenarios.
// Honors UART_ARB_LOCK_EN for the lock scenario's expected order.
module tb_uart_tx_arb;
    localparam int NREQ    = 4;
    localparam int BUSY_TO = 16;
    localparam int TXLEN   = 3;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   reqVec;
    logic [8*NREQ-1:0] datVec;
    logic [NREQ-1:0]   lockVec;
    logic [NREQ-1:0]   ackOut;
    logic [NREQ-1:0]   grantOut;
    logic              wrOut;
    logic [7:0]        datOut;
    logic              busyIn;
    logic              busyOut;
    logic              errOut;
    logic              errClr;

    int   tests;
    int   failures;
    logic txMode;
    logic forceBusy;

    // Model state: current owner (-1 when none), cycles since the strobe, and whether busy was seen.
    int         ownerM;
    int         ageM;
    int         lastM;
    int         lockM;
    int         candM;
    logic       sawBusyM;
    logic       errM;
    logic [7:0] datM;

    int   fairSeq[6]    = '{0, 1, 2, 3, 0, 1};
    logic [7:0] fairDat[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
`ifdef UART_ARB_LOCK_EN
    int   lockSeq[5]    = '{2, 2, 2, 0, 0};
    logic [7:0] lockDat[5] = '{8'hA1, 8'hA2, 8'hA3, 8'h0F, 8'h0F};
`else
    int   lockSeq[5]    = '{2, 0, 2, 0, 2};
    logic [7:0] lockDat[5] = '{8'hA1, 8'h0F, 8'hA2, 8'h0F, 8'hA3};
`endif

    uart_tx_arb #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .req_i       (reqVec),
        .dat_i       (datVec),
        .lock_i      (lockVec),
        .ack_o       (ackOut),
        .grant_o     (grantOut),
        .uart_wr_o   (wrOut),
        .uart_dat_o  (datOut),
        .uart_busy_i (busyIn),
        .busy_o      (busyOut),
        .err_o       (errOut),
        .err_clr_i   (errClr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pickWinner(input int last, input logic [NREQ-1:0] mask);
        for (int step = 1; step <= NREQ; step++) begin
            int k;
            k = (last + step) % NREQ;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] eligMask(input int owner, input logic [NREQ-1:0] lk,
                                                 input logic [NREQ-1:0] rq);
        if (owner >= 0 && lk[owner]) return rq & (NREQ'(1) << owner);
        return rq;
    endfunction

    function automatic int oneHotIdx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] d,
                                 input logic [NREQ-1:0] lk);
        reqVec  = r;
        datVec  = d;
        lockVec = lk;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},   32'(ackOut),   32'd0);
        checkOutput({tag, "_grant"}, 32'(grantOut), 32'd0);
        checkOutput({tag, "_wr"},    32'(wrOut),    32'd0);
        checkOutput({tag, "_dat"},   32'(datOut),   32'd0);
        checkOutput({tag, "_busy"},  32'(busyOut),  32'd0);
        checkOutput({tag, "_err"},   32'(errOut),   32'd0);
    endtask

    task automatic waitStrobe(input int budget, output int waited, output int idx, output logic [7:0] d);
        waited = 0;
        idx    = -1;
        d      = 8'h00;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (wrOut) begin
                idx = oneHotIdx(grantOut);
                d   = datOut;
                return;
            end
        end
        checkOutput("strobe_wait", 32'(wrOut), 32'd1);
    endtask

    task automatic waitIdle(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (!busyOut) return;
        end
        checkOutput("idle_wait", 32'(busyOut), 32'd0);
    endtask

    task automatic resetDut();
        nextCycle();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0);
        repeat (2) nextCycle();
        rst_n = 1'b1;
    endtask

    // Transmitter stand-in: goes busy the cycle after a strobe for TXLEN cycles, or is held busy.
    initial begin
        int   txLeft;
        logic wrSeen;
        txLeft = 0;
        busyIn = 1'b0;
        forever begin
            @(negedge clk);
            wrSeen = wrOut;
            @(posedge clk);
            #1;
            if (txMode && wrSeen) txLeft = TXLEN;
            busyIn = forceBusy || (txLeft > 0);
            if (txLeft > 0) txLeft--;
        end
    end

    always_comb candM = pickWinner(lastM, eligMask(lockM, lockVec, reqVec));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ownerM   <= -1;
            ageM     <= 0;
            sawBusyM <= 1'b0;
            lastM    <= NREQ - 1;
            lockM    <= -1;
            errM     <= 1'b0;
            datM     <= 8'h00;
        end else begin
            if (errClr) errM <= 1'b0;
            if (ownerM < 0) begin
                if (lockM >= 0 && !lockVec[lockM]) lockM <= -1;
                if (candM >= 0 && !busyIn) begin
                    ownerM   <= candM;
                    ageM     <= 0;
                    sawBusyM <= 1'b0;
                    datM     <= datVec[8*candM +: 8];
                end
            end else if (ageM == 0) begin
                ageM <= 1;
            end else if (!sawBusyM) begin
                if (busyIn) sawBusyM <= 1'b1;
                else if (ageM == BUSY_TO) begin
                    errM   <= 1'b1;
                    ownerM <= -1;
                end else ageM <= ageM + 1;
            end else begin
`ifdef UART_ARB_LOCK_EN
                if (lockVec[ownerM]) lockM <= ownerM;
`endif
                if (!busyIn) begin
                    ownerM <= -1;
                    lastM  <= ownerM;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic strobeExp;
            logic [NREQ-1:0] grantExp;
            strobeExp = (ownerM >= 0) && (ageM == 0);
            grantExp  = (ownerM >= 0) ? (NREQ'(1) << ownerM) : NREQ'(0);
            checkOutput("model_wr",    32'(wrOut),    32'(strobeExp));
            checkOutput("model_ack",   32'(ackOut),   strobeExp ? 32'(grantExp) : 32'd0);
            checkOutput("model_grant", 32'(grantOut), 32'(grantExp));
            checkOutput("model_busy",  32'(busyOut),  32'(ownerM >= 0));
            checkOutput("model_err",   32'(errOut),   32'(errM));
            if (strobeExp) checkOutput("model_dat", 32'(datOut), 32'(datM));
        end
    end

    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000 ns");
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         waited;
        int         idx;
        int         bc;
        int         n;
        int         c2;
        int         wrCount;
        logic [7:0] d;
        logic [NREQ-1:0]   r;
        logic [NREQ-1:0]   lk;
        logic [8*NREQ-1:0] dt;

        tests     = 0;
        failures  = 0;
        txMode    = 1'b1;
        forceBusy = 1'b0;
        errClr    = 1'b0;
        rst_n     = 1'b1;
        applyStimulus('0, '0, '0);
        #1 rst_n = 1'b0;
        #2 checkAllZero("por");
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkAllZero("post_reset");

        // Single request from requester 0.
        nextCycle();
        applyStimulus(4'b0001, 32'h0000_0055, '0);
        waitStrobe(20, waited, idx, d);
        checkOutput("single_latency", 32'(waited), 32'd2);
        checkOutput("single_dat",     32'(d),        32'h55);
        checkOutput("single_ack",     32'(ackOut),   32'b0001);
        checkOutput("single_grant",   32'(grantOut), 32'b0001);
        nextCycle();
        applyStimulus('0, '0, '0);
        bc = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busyOut) break;
            bc++;
        end
        checkOutput("single_busy_len", 32'(bc), 32'd5);
        checkOutput("single_tx_idle",  32'(busyIn), 32'd0);

        // Fairness with all requesters held high, starting from reset priority.
        resetDut();
        nextCycle();
        applyStimulus(4'b1111, 32'h4433_2211, '0);
        for (int s = 0; s < 6; s++) begin
            waitStrobe(20, waited, idx, d);
            checkOutput("fair_grant", 32'(idx), 32'(fairSeq[s]));
            checkOutput("fair_dat",   32'(d),   32'(fairDat[s]));
            checkOutput("fair_spacing", 32'(waited), (s == 0) ? 32'd2 : 32'd6);
        end
        nextCycle();
        applyStimulus('0, '0, '0);
        waitIdle(20);

        // Busy timeout with a dead transmitter, then clear.
        txMode = 1'b0;
        nextCycle();
        applyStimulus(4'b0100, 32'h00C3_0000, '0);
        waitStrobe(20, waited, idx, d);
        checkOutput("to_grant", 32'(idx), 32'd2);
        checkOutput("to_dat",   32'(d),   32'hC3);
        nextCycle();
        applyStimulus('0, '0, '0);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (errOut) break;
        end
        checkOutput("to_latency", 32'(n), 32'(BUSY_TO + 1));
        checkOutput("to_idle_busy",  32'(busyOut),  32'd0);
        checkOutput("to_idle_grant", 32'(grantOut), 32'd0);
        nextCycle();
        errClr = 1'b1;
        nextCycle();
        errClr = 1'b0;
        @(negedge clk);
        checkOutput("err_clear", 32'(errOut), 32'd0);

        // Timeout coinciding with a clear request: the set must win.
        nextCycle();
        applyStimulus(4'b0100, 32'h00C3_0000, '0);
        waitStrobe(20, waited, idx, d);
        nextCycle();
        applyStimulus('0, '0, '0);
        repeat (BUSY_TO - 1) nextCycle();
        errClr = 1'b1;
        nextCycle();
        errClr = 1'b0;
        @(negedge clk);
        checkOutput("err_set_wins", 32'(errOut), 32'd1);
        checkOutput("err_set_idle", 32'(busyOut), 32'd0);
        nextCycle();
        errClr = 1'b1;
        nextCycle();
        errClr = 1'b0;
        @(negedge clk);
        checkOutput("err_clear2", 32'(errOut), 32'd0);
        txMode = 1'b1;

        // Requester 2 sends a three-byte message while requester 0 competes.
        resetDut();
        nextCycle();
        r  = 4'b0100;
        lk = 4'b0100;
        dt = 32'h00A1_000F;
        applyStimulus(r, dt, lk);
        c2 = 0;
        for (int s = 0; s < 5; s++) begin
            waitStrobe(30, waited, idx, d);
            checkOutput("lock_grant", 32'(idx), 32'(lockSeq[s]));
            checkOutput("lock_dat",   32'(d),   32'(lockDat[s]));
            nextCycle();
            if (idx == 2) begin
                c2++;
                if (c2 == 1) r[0] = 1'b1;
                dt[23:16] = (c2 == 1) ? 8'hA2 : 8'hA3;
                if (c2 == 3) begin
                    r[2]  = 1'b0;
                    lk[2] = 1'b0;
                end
                applyStimulus(r, dt, lk);
            end
        end
        applyStimulus('0, '0, '0);
        waitIdle(30);

        // Reset while waiting for the transmitter to finish, with the transmitter kept busy afterwards.
        nextCycle();
        applyStimulus(4'b0010, 32'h0000_5A00, '0);
        waitStrobe(20, waited, idx, d);
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_in_transfer", 32'(busyOut), 32'd1);
        forceBusy = 1'b1;
        #2 rst_n = 1'b0;
        #1 checkAllZero("mid_reset");
        repeat (2) nextCycle();
        @(negedge clk);
        #2 rst_n = 1'b1;
        wrCount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wrOut) wrCount++;
        end
        checkOutput("hold_no_strobe", 32'(wrCount), 32'd0);
        checkOutput("hold_idle_busy", 32'(busyOut), 32'd0);
        nextCycle();
        forceBusy = 1'b0;
        waitStrobe(20, waited, idx, d);
        checkOutput("resume_grant", 32'(idx), 32'd1);
        checkOutput("resume_dat",   32'(d),   32'h5A);
        nextCycle();
        applyStimulus('0, '0, '0);
        waitIdle(20);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
